mem_access_unit: RTL and testbench

Memory-stage load/store unit sitting directly downstream of the EX/MEM pipeline register. Consumes the registered memory-stage controls (read/write strobes, ALU result as address, forwarded store operand, instruction word), issues one aligned access on a valid/ready data bus with byte enables, stalls the pipeline until the access completes, and returns a lane-extracted, sign- or zero-extended load result to the MEM/WB path. Faults and bus timeouts are reported without issuing or completing the access.

---
 rtl/mem_pkg.sv | 62 ++++++
 rtl/load_align.sv | 28 ++
 rtl/mem_access_unit.sv | 129 ++++++++++++
 tb/tb_mem_access_unit.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared memory-stage definitions: funct3 encodings, FSM states, store lane helpers.
// No logic of its own; pure functions only.
// Imported by the load/store unit and its load alignment slice.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2,
    DONE   = 2'd3
  } mem_state_t;

  typedef struct packed {
    logic [3:0]  be;
    logic [31:0] wdata;
  } lanes_t;

  // Replicate store data across every lane so the slave only needs the byte enables.
  function automatic lanes_t store_lanes(input logic [2:0] f3, input logic [1:0] lane,
                                         input logic [31:0] d);
    lanes_t l;
    case (f3)
      F3_B, F3_BU: begin
        l.be    = 4'b0001 << lane;
        l.wdata = {4{d[7:0]}};
      end
      F3_H, F3_HU: begin
        l.be    = 4'b0011 << lane;
        l.wdata = {2{d[15:0]}};
      end
      default: begin
        l.be    = 4'b1111;
        l.wdata = d;
      end
    endcase
    return l;
  endfunction

  function automatic logic access_legal(input logic rd, input logic wr,
                                        input logic [2:0] f3, input logic [1:0] lane);
    logic ok;
    ok = 1'b0;
    if (rd ^ wr) begin
      case (f3)
        F3_B:    ok = 1'b1;
        F3_BU:   ok = rd;
        F3_H:    ok = !lane[0];
        F3_HU:   ok = rd && !lane[0];
        F3_W:    ok = (lane == 2'b00);
        default: ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/load_align.sv
// Lane extraction of a read word plus sign/zero extension by access size.
// Latency: combinational.
// Backpressure: none; pure datapath.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0] shifted;

  assign shifted = rdata >> {lane, 3'b000};

  always_comb begin
    data = shifted;
    case (funct3)
      F3_B:    data = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   data = {24'h0, shifted[7:0]};
      F3_H:    data = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   data = {16'h0, shifted[15:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: one aligned valid/ready bus access per load/store.
// Latency: 2 cycles minimum (IDLE, REQ+ready(+rvalid), DONE); +1 per wait cycle.
// Backpressure: stall_o holds the pipeline until DONE; request held until dbus_ready.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEMREAD_MEM,
  input  logic        MEMWRITE_MEM,
  input  logic [31:0] ALUOUT_MEM,
  input  logic [31:0] PREOP2_MEM,
  input  logic [31:0] INSTR_MEM,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [31:0] dbus_wdata,
  output logic [3:0]  dbus_be,
  input  logic        dbus_ready,
  input  logic        dbus_rvalid,
  input  logic [31:0] dbus_rdata,
  output logic        stall_o,
  output logic [31:0] load_data_o,
  output logic        mem_done_o,
  output logic        fault_o,
  output logic        bus_err_o
);

  mem_state_t  state;
  logic [2:0]  f3_q;
  logic [1:0]  lane_q;
  logic [31:0] tmo_cnt;
  logic [31:0] aligned;
  logic [2:0]  funct3;
  logic        op, legal, busy, expiring, completing, abort;
  lanes_t      lanes;
  logic        unused_instr;

  assign funct3       = INSTR_MEM[14:12];
  assign unused_instr = ^{INSTR_MEM[31:15], INSTR_MEM[11:0]};
  assign op           = MEMREAD_MEM | MEMWRITE_MEM;
  assign legal        = access_legal(MEMREAD_MEM, MEMWRITE_MEM, funct3, ALUOUT_MEM[1:0]);
  assign lanes        = store_lanes(funct3, ALUOUT_MEM[1:0], PREOP2_MEM);

  assign stall_o = op && legal && (state != DONE);
  assign fault_o = (state == IDLE) && op && !legal;

  // Counter holds the number of cycles already spent, so the last allowed cycle is TIMEOUT-1.
  assign busy       = (state == REQ) || (state == WAIT_R);
  assign expiring   = (TIMEOUT_CYCLES != 0) && (tmo_cnt >= TIMEOUT_CYCLES - 1);
  assign completing = ((state == REQ) && dbus_ready && (dbus_we || dbus_rvalid)) ||
                      ((state == WAIT_R) && dbus_rvalid);
  assign abort      = busy && expiring && !completing;
  assign bus_err_o  = abort;

  load_align u_load_align (
    .rdata  (dbus_rdata),
    .lane   (lane_q),
    .funct3 (f3_q),
    .data   (aligned)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      dbus_req    <= 1'b0;
      dbus_we     <= 1'b0;
      dbus_addr   <= 32'h0;
      dbus_wdata  <= 32'h0;
      dbus_be     <= 4'h0;
      load_data_o <= 32'h0;
      mem_done_o  <= 1'b0;
      tmo_cnt     <= 32'h0;
      f3_q        <= 3'b000;
      lane_q      <= 2'b00;
    end else begin
      mem_done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (op && legal) begin
            state      <= REQ;
            dbus_req   <= 1'b1;
            dbus_we    <= MEMWRITE_MEM;
            dbus_addr  <= {ALUOUT_MEM[31:2], 2'b00};
            dbus_wdata <= lanes.wdata;
            dbus_be    <= lanes.be;
            f3_q       <= funct3;
            lane_q     <= ALUOUT_MEM[1:0];
            tmo_cnt    <= 32'h0;
          end
        end
        REQ: begin
          if (completing) begin
            dbus_req   <= 1'b0;
            state      <= DONE;
            mem_done_o <= 1'b1;
            if (!dbus_we) load_data_o <= aligned;
          end else if (abort) begin
            dbus_req   <= 1'b0;
            state      <= DONE;
            mem_done_o <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
            if (dbus_ready) begin
              dbus_req <= 1'b0;
              state    <= WAIT_R;
            end
          end
        end
        WAIT_R: begin
          if (dbus_rvalid) begin
            load_data_o <= aligned;
            state       <= DONE;
            mem_done_o  <= 1'b1;
          end else if (abort) begin
            state      <= DONE;
            mem_done_o <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a transaction-level expectation model.
module tb_mem_access_unit;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        MEMREAD_MEM, MEMWRITE_MEM;
  logic [31:0] ALUOUT_MEM, PREOP2_MEM, INSTR_MEM;
  logic        dbus_req, dbus_we;
  logic [31:0] dbus_addr, dbus_wdata;
  logic [3:0]  dbus_be;
  logic        dbus_ready, dbus_rvalid;
  logic [31:0] dbus_rdata;
  logic        stall_o, mem_done_o, fault_o, bus_err_o;
  logic [31:0] load_data_o;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst),
    .MEMREAD_MEM(MEMREAD_MEM), .MEMWRITE_MEM(MEMWRITE_MEM),
    .ALUOUT_MEM(ALUOUT_MEM), .PREOP2_MEM(PREOP2_MEM), .INSTR_MEM(INSTR_MEM),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_wdata(dbus_wdata), .dbus_be(dbus_be),
    .dbus_ready(dbus_ready), .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata),
    .stall_o(stall_o), .load_data_o(load_data_o), .mem_done_o(mem_done_o),
    .fault_o(fault_o), .bus_err_o(bus_err_o)
  );

  int n_chk = 0;
  int n_pass = 0;

  logic        chk_en = 1'b0;
  logic        e_stall, e_fault, e_req, e_done, e_err, e_we, e_zero_bus;
  logic [31:0] e_addr, e_wdata, e_load;
  logic [3:0]  e_be;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- expectation model ----------------
  function automatic int m_size(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      default:    return 4;
    endcase
  endfunction

  function automatic bit m_legal(input bit rd, input bit wr, input logic [2:0] f3,
                                 input logic [31:0] a);
    if (rd == wr) return 0;
    if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 0;
    if (wr && f3 >= 3'd4) return 0;
    return (a % m_size(f3)) == 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    logic [7:0] m;
    m = 8'((1 << m_size(f3)) - 1);
    m = m << a[1:0];
    return m[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    if (m_size(f3) == 1) return {24'h0, d[7:0]} * 32'h01010101;
    if (m_size(f3) == 2) return {16'h0, d[15:0]} * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] rdat);
    logic [31:0] v, mask;
    int sz;
    sz = m_size(f3);
    v  = rdat >> (8 * a[1:0]);
    if (sz == 4) return v;
    mask = (32'h1 << (8 * sz)) - 32'h1;
    if (f3 < 3'd4 && v[8*sz-1]) return v | ~mask;
    return v & mask;
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall_o", {31'h0, stall_o}, {31'h0, e_stall});
      chk("fault_o", {31'h0, fault_o}, {31'h0, e_fault});
      chk("mem_done_o", {31'h0, mem_done_o}, {31'h0, e_done});
      chk("bus_err_o", {31'h0, bus_err_o}, {31'h0, e_err});
      chk("dbus_req", {31'h0, dbus_req}, {31'h0, e_req});
      chk("load_data_o", load_data_o, e_load);
      if (e_req) begin
        chk("dbus_we", {31'h0, dbus_we}, {31'h0, e_we});
        chk("dbus_addr", dbus_addr, e_addr);
        chk("dbus_be", {28'h0, dbus_be}, {28'h0, e_be});
        if (e_we) chk("dbus_wdata", dbus_wdata, e_wdata);
      end
      if (e_zero_bus) begin
        chk("rst_we", {31'h0, dbus_we}, 32'h0);
        chk("rst_addr", dbus_addr, 32'h0);
        chk("rst_wdata", dbus_wdata, 32'h0);
        chk("rst_be", {28'h0, dbus_be}, 32'h0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input bit rdy, input bit rv, input logic [31:0] rdat);
    MEMREAD_MEM  = rd;
    MEMWRITE_MEM = wr;
    ALUOUT_MEM   = a;
    PREOP2_MEM   = d;
    INSTR_MEM    = {17'h0, f3, 12'h003};
    dbus_ready   = rdy;
    dbus_rvalid  = rv;
    dbus_rdata   = rdat;
  endtask

  task automatic set_exp(input bit st, input bit fl, input bit rq, input bit dn, input bit er);
    e_stall = st; e_fault = fl; e_req = rq; e_done = dn; e_err = er;
  endtask

  // r: cycle of dbus_ready, v: cycle of dbus_rvalid (cycle 0 = op first presented).
  task automatic run_op(input string nm, input bit rd, input bit wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d, input int r, input int v,
                        input logic [31:0] rdat, input logic [3:0] lbe, input logic [31:0] lwd,
                        input logic [31:0] lld, input int lstall);
    bit legal, to;
    int comp, e, last, stalls, rq_end;
    legal  = m_legal(rd, wr, f3, a);
    comp   = wr ? r : v;
    to     = comp > T;
    e      = to ? T : comp;
    last   = legal ? e + 1 : 0;
    rq_end = (r < e) ? r : e;
    stalls = 0;
    for (int k = 0; k <= last; k++) begin
      @(posedge clk); #1;
      drive(rd, wr, f3, a, d, legal && k == r, (rd && k == v) || (wr && k == r),
            (rd && k == v) ? rdat : 32'h5A5A5A5A);
      set_exp(legal && k <= e, !legal && k == 0, legal && k >= 1 && k <= rq_end,
              legal && k == e + 1, legal && to && k == e);
      e_we = wr; e_addr = {a[31:2], 2'b00}; e_be = m_be(f3, a); e_wdata = m_wdata(f3, d);
      if (legal && rd && !to && k == e + 1) e_load = m_load(f3, a, rdat);
      e_zero_bus = 1'b0;
      chk_en = 1'b1;
      @(negedge clk);
      if (stall_o) stalls++;
      if (wr && k == 1) begin
        chk({nm, "_be"}, {28'h0, dbus_be}, {28'h0, lbe});
        chk({nm, "_wdata"}, dbus_wdata, lwd);
      end
      if (k == last) chk({nm, "_load"}, load_data_o, lld);
    end
    chk({nm, "_stalls"}, stalls, lstall);
  endtask

  task automatic idle(input int n, input bit stray);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      drive(0, 0, 3'd0, 32'h0, 32'h0, 0, stray && k == 0, 32'hFFFFFFFF);
      set_exp(0, 0, 0, 0, 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 3'd0, 32'h0, 32'h0, 0, 0, 32'h0);
    set_exp(0, 0, 0, 0, 0);
    e_we = 0; e_addr = 0; e_be = 0; e_wdata = 0; e_load = 32'h0; e_zero_bus = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1, 0);

    run_op("sw",  0, 1, 3'd2, 32'h1000, 32'hDEADBEEF, 1, 99, 0, 4'hF, 32'hDEADBEEF, 32'h0, 2);
    run_op("sb",  0, 1, 3'd0, 32'h1003, 32'h000000A5, 1, 99, 0, 4'b1000, 32'hA5A5A5A5, 32'h0, 2);
    run_op("sh",  0, 1, 3'd1, 32'h1002, 32'h1234BEEF, 2, 99, 0, 4'b1100, 32'hBEEFBEEF, 32'h0, 3);
    run_op("lb",  1, 0, 3'd0, 32'h2001, 0, 1, 4, 32'h00008000, 0, 0, 32'hFFFFFF80, 5);
    run_op("lbu", 1, 0, 3'd4, 32'h2001, 0, 1, 4, 32'h00008000, 0, 0, 32'h00000080, 5);
    run_op("lh",  1, 0, 3'd1, 32'h2002, 0, 1, 1, 32'h80010000, 0, 0, 32'hFFFF8001, 2);
    run_op("lhu", 1, 0, 3'd5, 32'h2002, 0, 2, 3, 32'h80010000, 0, 0, 32'h00008001, 4);
    run_op("lw",  1, 0, 3'd2, 32'h2004, 0, 1, 2, 32'hCAFEF00D, 0, 0, 32'hCAFEF00D, 3);
    idle(1, 0);

    run_op("f_lw_mis", 1, 0, 3'd2, 32'h2002, 0, 1, 1, 32'h11111111, 0, 0, 32'hCAFEF00D, 0);
    run_op("f_sh_mis", 0, 1, 3'd1, 32'h1001, 32'h55, 1, 99, 0, 0, 0, 32'hCAFEF00D, 0);
    run_op("f_sbu",    0, 1, 3'd4, 32'h1000, 32'h55, 1, 99, 0, 0, 0, 32'hCAFEF00D, 0);
    run_op("f_both",   1, 1, 3'd2, 32'h1000, 32'h55, 1, 1, 0, 0, 0, 32'hCAFEF00D, 0);
    run_op("f_f3_3",   1, 0, 3'd3, 32'h1000, 0, 1, 1, 32'h22222222, 0, 0, 32'hCAFEF00D, 0);
    idle(1, 0);

    run_op("to_sw", 0, 1, 3'd2, 32'h4000, 32'h11223344, 99, 99, 0, 4'hF, 32'h11223344, 32'hCAFEF00D, 5);
    run_op("to_lw", 1, 0, 3'd2, 32'h4008, 0, 2, 99, 32'h33333333, 0, 0, 32'hCAFEF00D, 5);
    idle(2, 1);

    // Reset during WAIT_R, then a late rvalid that must be ignored.
    @(posedge clk); #1;
    drive(1, 0, 3'd2, 32'h3000, 0, 0, 0, 0);
    set_exp(1, 0, 0, 0, 0); e_we = 0; e_addr = 32'h3000; e_be = 4'hF;
    @(posedge clk); #1;
    drive(1, 0, 3'd2, 32'h3000, 0, 1, 0, 0);
    set_exp(1, 0, 1, 0, 0);
    @(posedge clk); #1;
    drive(1, 0, 3'd2, 32'h3000, 0, 0, 0, 0);
    rst = 1'b1;
    set_exp(1, 0, 0, 0, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(0, 0, 3'd0, 32'h0, 0, 0, 0, 0);
    set_exp(0, 0, 0, 0, 0); e_load = 32'h0; e_zero_bus = 1'b1;
    @(posedge clk); #1;
    drive(0, 0, 3'd0, 32'h0, 0, 0, 1, 32'h77777777);
    @(negedge clk);
    chk("rst_ignore_rvalid_load", load_data_o, 32'h0);
    idle(2, 0);

    run_op("sb_after_rst", 0, 1, 3'd0, 32'h5001, 32'h0000003C, 1, 99, 0, 4'b0010, 32'h3C3C3C3C, 32'h0, 2);
    idle(1, 0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
